// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer bundle for sync_fifo_flags. The master side (producer and
// consumer logic) drives the requests and write data; the slave side (the FIFO)
// returns read data, occupancy, threshold flags and error pulses.
interface sync_fifo_flags_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) ();
   localparam int CW = $clog2(DEPTH + 1);

   logic                  w_en;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  r_en;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [CW-1:0]         count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output w_en, data_in, r_en,
      input  data_out, full, empty, almost_full, almost_empty, count,
             overflow, underflow
   );

   modport slave (
      input  w_en, data_in, r_en,
      output data_out, full, empty, almost_full, almost_empty, count,
             overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with an exact occupancy counter, programmable almost-full
// and almost-empty thresholds, registered overflow/underflow pulses and an
// optional first-word-fall-through read port. DEPTH need not be a power of two:
// both pointers wrap explicitly at DEPTH-1.
module sync_fifo_flags #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = 2,
   parameter int FWFT       = 0
) (
   input logic               clk,
   input logic               rst,
   sync_fifo_flags_if.slave  bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         w_ptr;
   logic [PW-1:0]         r_ptr;
   logic [CW-1:0]         cnt;
   logic [DATA_WIDTH-1:0] dout_r;
   logic                  ovf_r;
   logic                  unf_r;

   logic full_c;
   logic empty_c;
   logic wr_ok;
   logic rd_ok;

   // Advance a pointer, returning to 0 after the last real entry.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return '0;
      end
      return p + PW'(1);
   endfunction

   // Status decodes of the registered count; accept qualifiers use only these,
   // so a full FIFO never writes through and an empty one never reads through.
   always_comb begin
      full_c  = (cnt == CW'(DEPTH));
      empty_c = (cnt == '0);
      wr_ok   = bus.w_en & ~full_c;
      rd_ok   = bus.r_en & ~empty_c;
   end

   // Storage array; contents survive reset, nothing is written while rst is high.
   always_ff @(posedge clk) begin
      if (!rst && wr_ok) begin
         mem[w_ptr] <= bus.data_in;
      end
   end

   // Pointers, occupancy and error pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_ptr <= '0;
         r_ptr <= '0;
         cnt   <= '0;
         ovf_r <= 1'b0;
         unf_r <= 1'b0;
      end else begin
         ovf_r <= bus.w_en & full_c;
         unf_r <= bus.r_en & empty_c;
         if (wr_ok) begin
            w_ptr <= next_ptr(w_ptr);
         end
         if (rd_ok) begin
            r_ptr <= next_ptr(r_ptr);
         end
         case ({wr_ok, rd_ok})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Registered read word: loaded on each accepted read in standard mode, held
   // otherwise; in FWFT mode it only supplies the post-reset value while empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_r <= '0;
      end else if (FWFT == 0 && rd_ok) begin
         dout_r <= mem[r_ptr];
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign bus.data_out = empty_c ? dout_r : mem[r_ptr];
      end else begin : g_std
         assign bus.data_out = dout_r;
      end
   endgenerate

   assign bus.full         = full_c;
   assign bus.empty        = empty_c;
   assign bus.almost_full  = (cnt >= CW'(AF_THRESH));
   assign bus.almost_empty = (cnt <= CW'(AE_THRESH));
   assign bus.count        = cnt;
   assign bus.overflow     = ovf_r;
   assign bus.underflow    = unf_r;
endmodule
